// File: rtl/cdc_xfer_arbiter.sv
// Round-robin arbiter sharing one CDC handshake source port among N_REQ requesters.
// Optional watchdog built when CDC_XFER_ARB_TIMEOUT_EN is defined; otherwise timeout_err is tied 0.
module cdc_xfer_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic [ID_W-1:0]   gnt_id,
  output logic [N_REQ-1:0]  done,
  output logic              hs_req,
  input  logic              hs_ready,
  output logic              busy,
  output logic              timeout_err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Handshake with the controller: hs_req is a level held from the grant until
  // hs_ready is seen low (request accepted); the transfer then completes when
  // hs_ready returns high. Requesters hold req until their done pulse.
  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               hs_req_q, hs_req_d;
  logic               busy_q, busy_d;
  logic [ID_W-1:0]    last_q, last_d;

  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;
  int                 cand;

  // Search begins one past the previous winner and wraps.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last_q) + k) % N_REQ;
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    done_d   = '0;
    hs_req_d = 1'b0;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        if (pick_found && hs_ready) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          gnt_id_d        = pick_idx;
          hs_req_d        = 1'b1;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        if (hs_ready) begin
          hs_req_d = 1'b1;
        end else begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (hs_ready) begin
          gnt_d            = '0;
          done_d[gnt_id_q] = 1'b1;
          last_d           = gnt_id_q;
          state_d          = DONE;
        end
      end
      DONE: begin
        // Dead cycle: no arbitration, guarantees a gap between transfers.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      done_q   <= '0;
      hs_req_q <= 1'b0;
      busy_q   <= 1'b0;
      last_q   <= ID_W'(N_REQ - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      done_q   <= done_d;
      hs_req_q <= hs_req_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
    end
  end

`ifdef CDC_XFER_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  // Watchdog only flags; a live handshake cannot be cancelled safely.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if ((state_q == ISSUE || state_q == BUSY) && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
    err_d = err_q | (cnt_d >= 16'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign done      = done_q;
  assign hs_req    = hs_req_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Directed bench for cdc_xfer_arbiter (N_REQ=4, TIMEOUT=16); the handshake
// controller is played by the driver tasks toggling hs_ready.
module tb_cdc_xfer_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic [3:0] done;
  logic       hs_req;
  logic       hs_ready;
  logic       busy;
  logic       timeout_err;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

`ifdef CDC_XFER_ARB_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  cdc_xfer_arbiter #(.N_REQ(4), .ID_W(2), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .done        (done),
    .hs_req      (hs_req),
    .hs_ready    (hs_ready),
    .busy        (busy),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Controller model for one transfer: waits for a grant, drops hs_ready one
  // cycle after accepting, holds it low for busy_cycles more, then raises it.
  // Returns at the falling edge of the DONE cycle.
  task automatic xfer(input int busy_cycles, output logic [3:0] g, output logic [1:0] id,
                      output logic [3:0] d, output logic hsr_after);
    logic found;
    found = 1'b0;
    g = '0; id = '0; d = '0; hsr_after = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (gnt != 4'b0000) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL xfer_wait: gnt=%b after 20 cycles, required a grant", gnt);
      return;
    end
    g  = gnt;
    id = gnt_id;
    hs_ready = 1'b0;
    step();
    hsr_after = hs_req;
    repeat (busy_cycles) step();
    hs_ready = 1'b1;
    step();
    d = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; hs_ready = 1'b1;
    step(); step();
    n_cmp++;
    if ({gnt, gnt_id, done, hs_req, busy, timeout_err} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_outputs: gnt=%b id=%0d done=%b hs_req=%b busy=%b to=%b, required all 0",
               gnt, gnt_id, done, hs_req, busy, timeout_err);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({gnt, busy, hs_req} !== 6'd0) begin
      n_err++;
      $display("FAIL reset_idle: gnt=%b busy=%b hs_req=%b, required 0", gnt, busy, hs_req);
    end
  endtask

  task automatic test_single();
    req = 4'b0100; hs_ready = 1'b1;
    step();
    n_cmp++;
    if ({gnt, gnt_id, hs_req, busy} !== {4'b0100, 2'd2, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL single_grant: gnt=%b id=%0d hs_req=%b busy=%b, required 0100 2 1 1",
               gnt, gnt_id, hs_req, busy);
    end
    hs_ready = 1'b0;
    step();
    n_cmp++;
    if ({hs_req, gnt} !== {1'b0, 4'b0100}) begin
      n_err++;
      $display("FAIL single_hsreq_pulse: hs_req=%b gnt=%b, required 0 0100", hs_req, gnt);
    end
    repeat (3) step();
    n_cmp++;
    if ({gnt, done, hs_req, busy} !== {4'b0100, 4'b0000, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL single_busy_hold: gnt=%b done=%b hs_req=%b busy=%b, required 0100 0000 0 1",
               gnt, done, hs_req, busy);
    end
    hs_ready = 1'b1;
    step();
    n_cmp++;
    if ({done, gnt, busy} !== {4'b0100, 4'b0000, 1'b1}) begin
      n_err++;
      $display("FAIL single_done: done=%b gnt=%b busy=%b, required 0100 0000 1", done, gnt, busy);
    end
    req = 4'b0000;
    step();
    n_cmp++;
    if ({done, busy, gnt_id} !== {4'b0000, 1'b0, 2'd2}) begin
      n_err++;
      $display("FAIL single_idle: done=%b busy=%b id=%0d, required 0000 0 2", done, busy, gnt_id);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_order [6];
    int         blen [6];
    logic [3:0] g, d;
    logic [1:0] id;
    logic       hsr;
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    blen      = '{2, 3, 1, 4, 2, 3};
    do_reset();
    req = 4'b1111; hs_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      xfer(blen[n], g, id, d, hsr);
      n_cmp++;
      if (id !== exp_order[n] || g !== (4'b0001 << exp_order[n])) begin
        n_err++;
        $display("FAIL fair_order[%0d]: id=%0d gnt=%b, required id %0d", n, id, g, exp_order[n]);
      end
      n_cmp++;
      if (d !== (4'b0001 << exp_order[n])) begin
        n_err++;
        $display("FAIL fair_done[%0d]: done=%b, required one bit at %0d", n, d, exp_order[n]);
      end
      if (n == 5) req = 4'b0000;
      step();
      n_cmp++;
      if ({gnt, done} !== 8'd0) begin
        n_err++;
        $display("FAIL fair_gap[%0d]: gnt=%b done=%b, required 0 0", n, gnt, done);
      end
    end
  endtask

  task automatic test_not_ready();
    int bad;
    bad = 0;
    hs_ready = 1'b0; req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step();
      if (gnt !== 4'b0000 || hs_req !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL notready_hold: %0d cycles with gnt or hs_req set, required 0", bad);
    end
    hs_ready = 1'b1;
    step();
    n_cmp++;
    if ({gnt, hs_req} !== {4'b0001, 1'b1}) begin
      n_err++;
      $display("FAIL notready_grant: gnt=%b hs_req=%b, required 0001 1", gnt, hs_req);
    end
    hs_ready = 1'b0;
    step(); step();
    hs_ready = 1'b1;
    step();
    n_cmp++;
    if (done !== 4'b0001) begin
      n_err++;
      $display("FAIL notready_done: done=%b, required 0001", done);
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_req_drop();
    req = 4'b0010; hs_ready = 1'b1;
    step();
    n_cmp++;
    if (gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL drop_grant: gnt=%b, required 0010", gnt);
    end
    hs_ready = 1'b0;
    step();
    req = 4'b0000;
    step(); step();
    n_cmp++;
    if ({gnt, busy} !== {4'b0010, 1'b1}) begin
      n_err++;
      $display("FAIL drop_hold: gnt=%b busy=%b, required 0010 1", gnt, busy);
    end
    hs_ready = 1'b1;
    step();
    n_cmp++;
    if (done !== 4'b0010) begin
      n_err++;
      $display("FAIL drop_done: done=%b, required 0010", done);
    end
    step();
    n_cmp++;
    if ({busy, gnt} !== 5'd0) begin
      n_err++;
      $display("FAIL drop_idle: busy=%b gnt=%b, required 0 0000", busy, gnt);
    end
  endtask

  task automatic test_timeout();
    req = 4'b0001; hs_ready = 1'b1;
    step();
    hs_ready = 1'b0;
    repeat (15) step();
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_early: timeout_err=%b after 15 cycles, required 0", timeout_err);
    end
    step();
    n_cmp++;
    if (timeout_err !== TO_EN || gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL timeout_set: timeout_err=%b gnt=%b, required %b 0001", timeout_err, gnt, TO_EN);
    end
    hs_ready = 1'b1;
    step();
    n_cmp++;
    if (done !== 4'b0001 || timeout_err !== TO_EN) begin
      n_err++;
      $display("FAIL timeout_complete: done=%b timeout_err=%b, required 0001 %b", done, timeout_err, TO_EN);
    end
    req = 4'b0000;
    step(); step();
    n_cmp++;
    if (timeout_err !== TO_EN || busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_sticky: timeout_err=%b busy=%b, required %b 0", timeout_err, busy, TO_EN);
    end
  endtask

  task automatic test_reset_mid_busy();
    int bad;
    bad = 0;
    req = 4'b1111; hs_ready = 1'b1;
    step();
    hs_ready = 1'b0;
    step(); step();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL rstbusy_pre: busy=%b, required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, gnt_id, done, hs_req, busy, timeout_err} !== 15'd0) begin
      n_err++;
      $display("FAIL rstbusy_async: gnt=%b id=%0d done=%b hs_req=%b busy=%b to=%b, required all 0",
               gnt, gnt_id, done, hs_req, busy, timeout_err);
    end
    hs_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done !== 4'b0000) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL rstbusy_no_done: %0d cycles with done set, required 0", bad);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({gnt, gnt_id} !== {4'b0001, 2'd0}) begin
      n_err++;
      $display("FAIL rstbusy_first: gnt=%b id=%0d, required 0001 0", gnt, gnt_id);
    end
    hs_ready = 1'b0;
    step(); step();
    hs_ready = 1'b1;
    req = 4'b0000;
    step();
    n_cmp++;
    if (done !== 4'b0001) begin
      n_err++;
      $display("FAIL rstbusy_done: done=%b, required 0001", done);
    end
    step();
  endtask

  initial begin
    rst_n = 1'b0; req = '0; hs_ready = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_not_ready();
    test_req_drop();
    test_timeout();
    test_reset_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
